// File: rtl/ext_irq_ctrl.sv
// rtl/ext_irq_ctrl.sv - device-side external interrupt controller (ExtIRQ/ExtIAck/ERet)
//
// Collects rising edges on N_SRC asynchronous device lines, latches them as
// sticky pending bits, picks the lowest pending index, and raises ExtIRQ
// toward the core. The selected ID is held through the handler and the
// controller re-arms only after ERet, so a handler is never re-interrupted.
//
// Optional feature macro: EXT_IRQ_CTRL_MASK_EN (adds irq_mask input).
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   irq_in       device interrupt lines, asynchronous, rising edge = request
//   irq_mask     (EXT_IRQ_CTRL_MASK_EN only) per-source enable, 1 = eligible
//   ExtIAck      core acknowledge, high for the cycle the core takes the irq
//   ERet         core exception return, one-cycle pulse
//   ExtIRQ       registered interrupt request to the core
//   irq_id       registered index of the source requested / in service
//   irq_pending  registered sticky pending bits
//   irq_lost     one-cycle pulse: edge arrived on an already pending source
module ext_irq_ctrl #(
  parameter int N_SRC = 4,
  parameter int ID_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_SRC-1:0]  irq_in,
`ifdef EXT_IRQ_CTRL_MASK_EN
  input  logic [N_SRC-1:0]  irq_mask,
`endif
  input  logic              ExtIAck,
  input  logic              ERet,
  output logic              ExtIRQ,
  output logic [ID_W-1:0]   irq_id,
  output logic [N_SRC-1:0]  irq_pending,
  output logic              irq_lost
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t           state;
  logic [N_SRC-1:0] sync1;
  logic [N_SRC-1:0] sync2;
  logic [N_SRC-1:0] hist;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr;
  logic [ID_W-1:0]  win_id;
  logic             any_eligible;

  // Two-flop synchronizer followed by a history flop for edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
      hist  <= '0;
    end else begin
      sync1 <= irq_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

`ifdef EXT_IRQ_CTRL_MASK_EN
  assign eligible = irq_pending & irq_mask;
`else
  assign eligible = irq_pending;
`endif

  assign any_eligible = |eligible;

  // Fixed priority: scanning from the top down leaves the lowest set index.
  always_comb begin
    win_id = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) win_id = ID_W'(i);
    end
  end

  // Pending bit of the requested source is cleared by the acknowledge.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if ((state == REQ) && ExtIAck && (irq_id == ID_W'(i))) clr[i] = 1'b1;
    end
  end

  // A new edge in the clearing cycle re-sets the bit (set wins) and is not
  // counted as lost, since the previous request has just been consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_pending <= '0;
      irq_lost    <= 1'b0;
    end else begin
      irq_pending <= (irq_pending & ~clr) | rise;
      irq_lost    <= |(rise & irq_pending & ~clr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ExtIRQ <= 1'b0;
      irq_id <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_eligible) begin
            state  <= REQ;
            ExtIRQ <= 1'b1;
            irq_id <= win_id;
          end
        end
        REQ: begin
          if (ExtIAck) begin
            state  <= SERVICE;
            ExtIRQ <= 1'b0;
          end
        end
        SERVICE: begin
          if (ERet) state <= IDLE;
        end
        default: begin
          state  <= IDLE;
          ExtIRQ <= 1'b0;
        end
      endcase
    end
  end

endmodule
